stm_gain_scheduler: RTL

- Sequences the gain-STM BRAM reader: on each sampling-timer UPDATE pulse, issues one START with a stable frame index.
- Tracks reader completion by counting its DOUT_VALID beats.
- Advances and wraps the frame index per segment.
- Handles double-buffered segment swap, finite repeat count and overrun detection.
- Sits between the STM timing/control registers and the gain reader.

---
 rtl/stm_gain_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/stm_gain_scheduler.sv
// Gain-STM frame scheduler: one reader START per accepted UPDATE, frame-index advance, segment swap, repeat and overrun.
// Build macro STM_GAIN_IMMEDIATE_SWAP_EN: a pending segment swap takes effect at the next frame completion instead of at wrap.
module stm_gain_scheduler #(
    parameter int DEPTH     = 249,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UPDATE,
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic [15:0]          REP,
    input  logic                 REQ_SEGMENT,
    input  logic                 SEG_SWAP,
    input  logic                 DOUT_VALID,
    output logic                 START,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 SEGMENT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN
);
    localparam int          BW      = $clog2(DEPTH) + 1;
    localparam logic [15:0] REP_INF = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;
    state_t state, state_next;

    logic [BW-1:0]        beat_cnt;
    logic [15:0]          pass_cnt;
    logic                 pend_valid;
    logic                 pend_seg;
    logic [IDX_WIDTH-1:0] cyc_cur;
    logic                 last_beat;

    // Handshake: UPDATE is accepted only in IDLE with DONE=0; each START obliges the reader to return DEPTH DOUT_VALID beats.
    assign cyc_cur   = SEGMENT ? CYCLE_1 : CYCLE_0;
    assign last_beat = (state == STREAM) && DOUT_VALID && (beat_cnt == BW'(DEPTH - 1));
    assign START     = (state == ISSUE);
    assign BUSY      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (UPDATE && !DONE) state_next = ISSUE;
            ISSUE:   state_next = STREAM;
            STREAM:  if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            pass_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_seg   <= 1'b0;
            IDX        <= '0;
            SEGMENT    <= 1'b0;
            DONE       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ISSUE)
                beat_cnt <= '0;
            else if (state == STREAM && DOUT_VALID)
                beat_cnt <= beat_cnt + BW'(1);

            if (UPDATE && BUSY)
                OVERRUN <= 1'b1;

            // Frame completion: the index changes only here, so it is stable for the reader while BUSY.
            if (last_beat) begin
`ifdef STM_GAIN_IMMEDIATE_SWAP_EN
                if (pend_valid) begin
                    SEGMENT    <= pend_seg;
                    IDX        <= '0;
                    pass_cnt   <= '0;
                    pend_valid <= 1'b0;
                end else
`endif
                if (IDX < cyc_cur) begin
                    IDX <= IDX + IDX_WIDTH'(1);
                end else if (pend_valid) begin
                    SEGMENT    <= pend_seg;
                    IDX        <= '0;
                    pass_cnt   <= '0;
                    pend_valid <= 1'b0;
                end else if (REP != REP_INF && pass_cnt == REP) begin
                    DONE <= 1'b1;
                    IDX  <= cyc_cur;
                end else begin
                    IDX <= '0;
                    if (pass_cnt != 16'hFFFF)
                        pass_cnt <= pass_cnt + 16'd1;
                end
            end

            // Later in the block so a swap request landing on the completion cycle is still recorded.
            if (SEG_SWAP) begin
                if (state == IDLE && DONE) begin
                    SEGMENT    <= REQ_SEGMENT;
                    IDX        <= '0;
                    pass_cnt   <= '0;
                    DONE       <= 1'b0;
                    pend_valid <= 1'b0;
                end else if (REQ_SEGMENT == SEGMENT) begin
                    pend_valid <= 1'b0;
                end else begin
                    pend_valid <= 1'b1;
                    pend_seg   <= REQ_SEGMENT;
                end
            end
        end
    end
endmodule
